jk_mod_counter: RTL and testbench

Parametrised synchronous register built from WIDTH JK cells. It runs either as a modulo-N up/down counter with load, terminal-count and wrap indication, or as a raw bank of independent JK flip-flops. It generalises the single JK flip-flop into a multi-bit, multi-mode block for the counter and divider paths in the design. All state changes on the rising edge of `clk`.

---
 rtl/jk_pkg.sv | 20 ++
 rtl/jk_cell.sv | 31 +++
 rtl/jk_mod_counter.sv | 98 +++++++++
 tb/tb_jk_mod_counter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared encodings for JK-cell based counters and dividers.
// Holds the mode select values and the per-cell JK function codes.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE_COUNT = 2'b00,
    JK_MODE_JK    = 2'b01,
    JK_MODE_HOLD  = 2'b10,
    JK_MODE_RSVD  = 2'b11
  } jk_mode_e;

  // {j, k} pair as seen by a single cell
  typedef enum logic [1:0] {
    JK_FN_HOLD   = 2'b00,
    JK_FN_CLEAR  = 2'b01,
    JK_FN_SET    = 2'b10,
    JK_FN_TOGGLE = 2'b11
  } jk_fn_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with enable; 1-cycle latency, holds whenever en is low.
// Reset is synchronous active-low and forces q to 0.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      case (jk_fn_e'({j, k}))
        JK_FN_HOLD:   q <= q;
        JK_FN_CLEAR:  q <= 1'b0;
        JK_FN_SET:    q <= 1'b1;
        JK_FN_TOGGLE: q <= ~q;
        default:      q <= q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter with load, or a raw bank of JK flip-flops; 1-cycle latency.
// No backpressure: load overrides en/mode, en=0 freezes all cells; tc is combinational.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  // WIDTH-bit constant so MODULUS = 2^WIDTH still fits
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nq;
  logic [WIDTH-1:0] j_int;
  logic [WIDTH-1:0] k_int;
  logic             wrap_nxt;
  logic             cell_en;

  always_comb begin
    nq       = q;
    wrap_nxt = 1'b0;
    if (load) begin
      nq = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      case (jk_mode_e'(mode))
        JK_MODE_COUNT: begin
          if (up) begin
            if (q < MAX_VAL) begin
              nq = q + 1'b1;
            end else if (SATURATE) begin
              nq = MAX_VAL;
            end else begin
              nq       = '0;
              wrap_nxt = 1'b1;
            end
          end else begin
            if (q == '0) begin
              if (!SATURATE) begin
                nq       = MAX_VAL;
                wrap_nxt = 1'b1;
              end
            end else if (q > MAX_VAL) begin
              // only reachable after JK mode left an out-of-range value
              nq = MAX_VAL;
            end else begin
              nq = q - 1'b1;
            end
          end
        end
        JK_MODE_JK: nq = (j & ~q) | (~k & q);
        default:    nq = q;
      endcase
    end
  end

  // Every update, including counting and load, goes through the cells as J/K pairs
  assign j_int   = nq & ~q;
  assign k_int   = ~nq & q;
  assign cell_en = load | en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (cell_en),
      .j    (j_int[i]),
      .k    (k_int[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_nxt;
    end
  end

  assign tc = up ? (q >= MAX_VAL) : (q == '0);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: wrapping instance (MODULUS=10) plus a saturating twin.
module tb_jk_mod_counter;
  import jk_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q, qbar, q_s, qbar_s;
  logic       tc, wrap, tc_s, wrap_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .up(up), .load(load),
    .load_val(load_val), .j(j), .k(k), .q(q), .qbar(qbar), .tc(tc), .wrap(wrap)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .up(up), .load(load),
    .load_val(load_val), .j(j), .k(k), .q(q_s), .qbar(qbar_s), .tc(tc_s), .wrap(wrap_s)
  );

  // advance one edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; load_val = 4'd5; en = 1'b1;
    mode = JK_MODE_COUNT; up = 1'b1; j = '0; k = '0;
    tick(); tick();
    tests++; if (q !== 4'd0) begin fails++; $display("FAIL reset_q got=%0d exp=0", q); end
    tests++; if (qbar !== 4'hF) begin fails++; $display("FAIL reset_qbar got=%h exp=f", qbar); end
    tests++; if (wrap !== 1'b0) begin fails++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    tests++; if (tc !== 1'b0) begin fails++; $display("FAIL reset_tc_up got=%b exp=0", tc); end
    up = 1'b0; #1;
    tests++; if (tc !== 1'b1) begin fails++; $display("FAIL reset_tc_down got=%b exp=1", tc); end
    up = 1'b1; rst_n = 1'b1; load = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      tests++; if (q !== 4'(n)) begin fails++; $display("FAIL count_after_reset got=%0d exp=%0d", q, n); end
    end
  endtask

  task automatic test_up_wrap();
    do_load(4'd8);
    tests++; if (q !== 4'd8) begin fails++; $display("FAIL up_load8 got=%0d exp=8", q); end
    tick();
    tests++; if (q !== 4'd9 || tc !== 1'b1) begin fails++; $display("FAIL up_at9 q=%0d tc=%b exp q=9 tc=1", q, tc); end
    tick();
    tests++; if (q !== 4'd0 || wrap !== 1'b1) begin fails++; $display("FAIL up_wrap q=%0d wrap=%b exp q=0 wrap=1", q, wrap); end
    tests++; if (q_s !== 4'd9 || wrap_s !== 1'b0) begin fails++; $display("FAIL up_sat q=%0d wrap=%b exp q=9 wrap=0", q_s, wrap_s); end
    tick();
    tests++; if (q !== 4'd1 || wrap !== 1'b0) begin fails++; $display("FAIL up_after_wrap q=%0d wrap=%b exp q=1 wrap=0", q, wrap); end
  endtask

  task automatic test_down_wrap();
    do_load(4'd1);
    up = 1'b0;
    tick();
    tests++; if (q !== 4'd0 || tc !== 1'b1) begin fails++; $display("FAIL down_at0 q=%0d tc=%b exp q=0 tc=1", q, tc); end
    tick();
    tests++; if (q !== 4'd9 || wrap !== 1'b1) begin fails++; $display("FAIL down_wrap q=%0d wrap=%b exp q=9 wrap=1", q, wrap); end
    tests++; if (q_s !== 4'd0 || wrap_s !== 1'b0 || tc_s !== 1'b1) begin fails++; $display("FAIL down_sat q=%0d wrap=%b tc=%b exp q=0 wrap=0 tc=1", q_s, wrap_s, tc_s); end
    tick();
    tests++; if (q !== 4'd8 || wrap !== 1'b0) begin fails++; $display("FAIL down_after_wrap q=%0d wrap=%b exp q=8 wrap=0", q, wrap); end
    tests++; if (q_s !== 4'd0 || wrap_s !== 1'b0) begin fails++; $display("FAIL down_sat_hold q=%0d wrap=%b exp q=0 wrap=0", q_s, wrap_s); end
  endtask

  task automatic test_load_clamp();
    up = 1'b1;
    do_load(4'd13);
    tests++; if (q !== 4'd9) begin fails++; $display("FAIL clamp13 got=%0d exp=9", q); end
    do_load(4'd15);
    tests++; if (q !== 4'd9) begin fails++; $display("FAIL clamp15 got=%0d exp=9", q); end
    load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0;
    tests++; if (q !== 4'd3 || wrap !== 1'b0) begin fails++; $display("FAIL load_vs_wrap q=%0d wrap=%b exp q=3 wrap=0", q, wrap); end
    en = 1'b0;
    do_load(4'd7);
    en = 1'b1;
    tests++; if (q !== 4'd7) begin fails++; $display("FAIL load_en0 got=%0d exp=7", q); end
  endtask

  task automatic test_jk();
    do_load(4'b0101);
    mode = JK_MODE_JK; j = 4'b1100; k = 4'b0110;
    tick();
    tests++; if (q !== 4'b1001 || qbar !== 4'b0110) begin fails++; $display("FAIL jk_func q=%b qbar=%b exp q=1001 qbar=0110", q, qbar); end
    j = 4'b1111; k = 4'b0000;
    tick();
    tests++; if (q !== 4'b1111 || tc !== 1'b1) begin fails++; $display("FAIL jk_set q=%b tc=%b exp q=1111 tc=1", q, tc); end
    mode = JK_MODE_COUNT; up = 1'b1;
    tick();
    tests++; if (q !== 4'd0 || wrap !== 1'b1) begin fails++; $display("FAIL jk_oor_up q=%0d wrap=%b exp q=0 wrap=1", q, wrap); end
    mode = JK_MODE_JK;
    tick();
    tests++; if (q !== 4'b1111 || wrap !== 1'b0) begin fails++; $display("FAIL jk_reset_wrap q=%b wrap=%b exp q=1111 wrap=0", q, wrap); end
    mode = JK_MODE_COUNT; up = 1'b0;
    tick();
    tests++; if (q !== 4'd9 || wrap !== 1'b0) begin fails++; $display("FAIL jk_oor_down q=%0d wrap=%b exp q=9 wrap=0", q, wrap); end
    j = '0; k = '0; up = 1'b1;
  endtask

  task automatic test_enable_hold();
    do_load(4'd9);
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      tests++; if (q !== 4'd9 || wrap !== 1'b0 || tc !== 1'b1) begin fails++; $display("FAIL en0_hold q=%0d wrap=%b tc=%b exp q=9 wrap=0 tc=1", q, wrap, tc); end
    end
    en = 1'b1; mode = JK_MODE_HOLD;
    tick();
    tests++; if (q !== 4'd9 || wrap !== 1'b0) begin fails++; $display("FAIL mode_hold q=%0d wrap=%b exp q=9 wrap=0", q, wrap); end
    mode = 2'b11;
    tick();
    tests++; if (q !== 4'd9 || wrap !== 1'b0) begin fails++; $display("FAIL mode_rsvd q=%0d wrap=%b exp q=9 wrap=0", q, wrap); end
    mode = JK_MODE_COUNT;
    tick();
    tests++; if (q !== 4'd0 || wrap !== 1'b1) begin fails++; $display("FAIL resume_count q=%0d wrap=%b exp q=0 wrap=1", q, wrap); end
  endtask

  task automatic test_back_to_back();
    do_load(4'd5);
    up = 1'b1;
    tick();
    tests++; if (q !== 4'd6) begin fails++; $display("FAIL dir_up got=%0d exp=6", q); end
    up = 1'b0;
    tick();
    tests++; if (q !== 4'd5) begin fails++; $display("FAIL dir_down got=%0d exp=5", q); end
    load = 1'b1; load_val = 4'd4; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; load = 1'b0;
    tests++; if (q !== 4'd0 || wrap !== 1'b0) begin fails++; $display("FAIL reset_over_load q=%0d wrap=%b exp q=0 wrap=0", q, wrap); end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_jk();
    test_enable_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
